mac_acc_engine: RTL and testbench

//  Parametrised successor to the fixed 4-lane mac/acc pair. Takes LANES signed ifm/weight pairs per beat,

---
 rtl/mac_acc_engine.sv | 170 +++++++++++++++++
 tb/tb_mac_acc_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mac_acc_engine.sv
// Multiply-accumulate engine: LANES signed products per beat, tree reduction, accumulation over
// cfg_len beats, optional partial-sum seed, ReLU and output saturation. Three register stages.
module mac_acc_engine #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 48,
  parameter int OW    = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic                  cfg_relu,
  input  logic                  cfg_psum,
  input  logic [OW-1:0]         psum_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   ifm,
  input  logic [LANES*DW-1:0]   wgt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic                  out_sat,
  output logic                  busy
);

  localparam int PW = 2 * DW;
  localparam logic signed [AW-1:0] OMAX = (AW'(1) <<< (OW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] OMIN = -OMAX - AW'(1);

  logic stall;
  logic accept;
  logic first;
  logic last;
  logic [CNT_W-1:0] eff_len;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             relu_q;

  logic signed [PW-1:0] prod_d [LANES];
  logic signed [PW-1:0] prod_q [LANES];
  logic                 s1_v_q, s1_first_q, s1_last_q, s1_psum_q, s1_relu_q;
  logic [OW-1:0]        s1_pin_q;

  logic signed [AW-1:0] node [2*LANES-1];
  logic signed [AW-1:0] s2_sum_q;
  logic                 s2_v_q, s2_first_q, s2_last_q, s2_psum_q, s2_relu_q;
  logic [OW-1:0]        s2_pin_q;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] relu_val;
  logic [OW-1:0]        res_d;
  logic                 sat_d;

  logic                 out_valid_q;
  logic [OW-1:0]        out_data_q;
  logic                 out_sat_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // On a first beat the length comes straight from cfg_len, since len_q is only latched then.
  assign first   = (cnt_q == '0);
  assign eff_len = first ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : len_q;
  assign last    = (cnt_q == eff_len - CNT_W'(1));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mul
      assign prod_d[gi] = $signed(ifm[gi*DW +: DW]) * $signed(wgt[gi*DW +: DW]);
    end
  endgenerate

  // Heap-ordered reduction tree: leaves at LANES-1.., root at node[0].
  always_comb begin
    for (int k = 0; k < 2*LANES-1; k++) node[k] = '0;
    for (int k = 0; k < LANES; k++)
      node[LANES-1+k] = {{(AW-PW){prod_q[k][PW-1]}}, prod_q[k]};
    for (int k = LANES-2; k >= 0; k--)
      node[k] = node[2*k+1] + node[2*k+2];
  end

  always_comb begin
    base     = s2_psum_q ? ({{(AW-OW){s2_pin_q[OW-1]}}, s2_pin_q} <<< FRAC) : '0;
    acc_d    = (s2_first_q ? base : acc_q) + s2_sum_q;
    shifted  = acc_d >>> FRAC;
    relu_val = (s2_relu_q && shifted < 0) ? '0 : shifted;
    sat_d    = 1'b0;
    res_d    = relu_val[OW-1:0];
    if (relu_val > OMAX) begin
      res_d = OMAX[OW-1:0];
      sat_d = 1'b1;
    end else if (relu_val < OMIN) begin
      res_d = OMIN[OW-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      len_q       <= CNT_W'(1);
      relu_q      <= 1'b0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_psum_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_pin_q    <= '0;
      s2_sum_q    <= '0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_psum_q   <= 1'b0;
      s2_relu_q   <= 1'b0;
      s2_pin_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      s1_v_q <= accept;
      if (accept) begin
        cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
        if (first) begin
          len_q  <= eff_len;
          relu_q <= cfg_relu;
        end
        for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
        s1_first_q <= first;
        s1_last_q  <= last;
        s1_psum_q  <= first & cfg_psum;
        s1_relu_q  <= first ? cfg_relu : relu_q;
        s1_pin_q   <= psum_in;
      end

      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_sum_q   <= node[0];
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_psum_q  <= s1_psum_q;
        s2_relu_q  <= s1_relu_q;
        s2_pin_q   <= s1_pin_q;
      end

      if (s2_v_q) acc_q <= acc_d;
      if (s2_v_q && s2_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_d;
        out_sat_q   <= sat_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (cnt_q != '0) | s1_v_q | s2_v_q;

endmodule

// File: tb/tb_mac_acc_engine.sv
// Directed bench for mac_acc_engine: hand-computed vectors covering latency, accumulation,
// saturation, ReLU, partial-sum seeding, backpressure and mid-neuron reset.
module tb_mac_acc_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_len;
  logic        cfg_relu;
  logic        cfg_psum;
  logic [15:0] psum_in;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ifm;
  logic [63:0] wgt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mac_acc_engine dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_relu(cfg_relu), .cfg_psum(cfg_psum),
    .psum_in(psum_in), .in_valid(in_valid), .in_ready(in_ready), .ifm(ifm), .wgt(wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] p4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [63:0] f, input logic [63:0] w, input logic [15:0] len,
                      input logic r, input logic ps, input logic [15:0] pin);
    int n;
    @(negedge clk);
    ifm = f; wgt = w; cfg_len = len; cfg_relu = r; cfg_psum = ps; psum_in = pin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [15:0] exp_d, input logic exp_s);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, {48'd0, out_data}, {48'd0, exp_d});
    chk({tag, "_sat"}, {63'd0, out_sat}, {63'd0, exp_s});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [63:0] v_ifm, v_one, v_7f, v_81;

  initial begin
    rst_n = 1'b0; cfg_len = '0; cfg_relu = 1'b0; cfg_psum = 1'b0; psum_in = '0;
    in_valid = 1'b0; ifm = '0; wgt = '0; out_ready = 1'b0;
    v_ifm = p4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    v_one = p4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    v_7f  = p4(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    v_81  = p4(16'h8100, 16'h8100, 16'h8100, 16'h8100);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {48'd0, out_data}, 64'd0);
    chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;

    // Latency: output appears on the third cycle after the accepting edge
    send(v_ifm, v_one, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    chk("lat_c1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_c2", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_c3", {63'd0, out_valid}, 64'd1);
    get_out("t1", 16'h0A00, 1'b0);

    send(v_ifm, v_one, 16'd0, 1'b0, 1'b0, 16'h0);
    idle();
    get_out("len0", 16'h0A00, 1'b0);

    // Three-beat neuron; cfg_len changes on later beats must be ignored
    send(v_ifm, v_one, 16'd3, 1'b0, 1'b0, 16'h0);
    send(v_ifm, v_one, 16'd1, 1'b0, 1'b0, 16'h0);
    send(v_ifm, v_one, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    get_out("len3", 16'h1E00, 1'b0);
    chk("len3_single", {63'd0, out_valid}, 64'd0);
    chk("len3_idle", {63'd0, busy}, 64'd0);

    send(v_7f, v_7f, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    get_out("sat_pos", 16'h7FFF, 1'b1);
    send(v_7f, v_81, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    get_out("sat_neg", 16'h8000, 1'b1);

    send(p4(16'hFB00, 16'h0, 16'h0, 16'h0), v_one, 16'd1, 1'b1, 1'b0, 16'h0);
    idle();
    get_out("relu_on", 16'h0000, 1'b0);
    send(p4(16'hFB00, 16'h0, 16'h0, 16'h0), v_one, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    get_out("relu_off", 16'hFB00, 1'b0);

    send(p4(16'h0200, 16'h0, 16'h0, 16'h0), v_one, 16'd1, 1'b0, 1'b1, 16'h0100);
    idle();
    get_out("psum_on", 16'h0300, 1'b0);
    send(p4(16'h0200, 16'h0, 16'h0, 16'h0), v_one, 16'd1, 1'b0, 1'b0, 16'h0100);
    idle();
    get_out("psum_off", 16'h0200, 1'b0);

    // Backpressure: two neurons queued while the consumer is not ready
    send(v_ifm, v_one, 16'd1, 1'b0, 1'b0, 16'h0);
    send(v_7f, v_81, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    @(negedge clk);
    chk("bp_vld", {63'd0, out_valid}, 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold_data", {48'd0, out_data}, 64'h0A00);
    chk("bp_hold_vld", {63'd0, out_valid}, 64'd1);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    get_out("bp_first", 16'h0A00, 1'b0);
    get_out("bp_second", 16'h8000, 1'b1);
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of a three-beat neuron
    send(v_ifm, v_one, 16'd3, 1'b0, 1'b0, 16'h0);
    idle();
    chk("mid_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_out_data", {48'd0, out_data}, 64'd0);
    chk("mr_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_no_output", {63'd0, out_valid}, 64'd0);
    send(v_ifm, v_one, 16'd1, 1'b0, 1'b0, 16'h0);
    idle();
    get_out("post_rst", 16'h0A00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
